// File: rtl/axi_lite_reg_subordinate.sv
// AXI-Lite register-file target: independent write/read FSMs, programmable response
// delay, SLVERR outside the register window, responses held until accepted.
//
// state     | meaning
// W_COLLECT | gathering write address and write data (either order)
// W_DELAY   | register committed on first cycle, counting response delay
// W_RESP    | bvalid high, waiting for bready
// R_IDLE    | arready high, waiting for a read address
// R_DELAY   | counting response delay
// R_RESP    | rvalid high with loaded data, waiting for rready

module axi_lite_reg_subordinate #(
   parameter int AXI_LITE_ADDR_WIDTH = 32,
   parameter int AXI_LITE_DATA_WIDTH = 32,
   parameter int NUM_REGS            = 16,
   parameter int RESP_DELAY          = 0
) (
   input  logic                           clk,
   input  logic                           ap_rst,
   input  logic                           S_AXIL_awvalid,
   output logic                           S_AXIL_awready,
   input  logic [AXI_LITE_ADDR_WIDTH-1:0] S_AXIL_awaddr,
   input  logic                           S_AXIL_wvalid,
   output logic                           S_AXIL_wready,
   input  logic [AXI_LITE_DATA_WIDTH-1:0] S_AXIL_wdata,
   output logic                           S_AXIL_bvalid,
   input  logic                           S_AXIL_bready,
   output logic [1:0]                     S_AXIL_bresp,
   input  logic                           S_AXIL_arvalid,
   output logic                           S_AXIL_arready,
   input  logic [AXI_LITE_ADDR_WIDTH-1:0] S_AXIL_araddr,
   output logic                           S_AXIL_rvalid,
   input  logic                           S_AXIL_rready,
   output logic [AXI_LITE_DATA_WIDTH-1:0] S_AXIL_rdata,
   output logic [1:0]                     S_AXIL_rresp,
   output logic [15:0]                    o_wr_count,
   output logic [15:0]                    o_rd_count
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [AXI_LITE_ADDR_WIDTH-1:0] ADDR_LIMIT = AXI_LITE_ADDR_WIDTH'(4 * NUM_REGS);
   localparam logic [7:0] DLY = 8'(RESP_DELAY);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_COLLECT, W_DELAY, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;

   logic [AXI_LITE_DATA_WIDTH-1:0] regs [NUM_REGS];

   w_state_t                       w_state, w_state_n;
   logic                           aw_held, aw_held_n, w_held, w_held_n;
   logic [AXI_LITE_ADDR_WIDTH-1:0] wr_addr, wr_addr_n;
   logic [AXI_LITE_DATA_WIDTH-1:0] wr_data, wr_data_n;
   logic [7:0]                     w_cnt, w_cnt_n;
   logic                           awready_n, wready_n, bvalid_n;
   logic [1:0]                     bresp_n;
   logic [15:0]                    wr_count_n;
   logic                           reg_we, wr_in_range;
   logic [IDX_W-1:0]               wr_idx;

   r_state_t                       r_state, r_state_n;
   logic [AXI_LITE_ADDR_WIDTH-1:0] rd_addr, rd_addr_n;
   logic [7:0]                     r_cnt, r_cnt_n;
   logic                           arready_n, rvalid_n;
   logic [AXI_LITE_DATA_WIDTH-1:0] rdata_n;
   logic [1:0]                     rresp_n;
   logic [15:0]                    rd_count_n;
   logic                           rd_in_range;
   logic [IDX_W-1:0]               rd_idx;

   assign wr_in_range = (wr_addr < ADDR_LIMIT);
   assign wr_idx      = wr_addr[2 +: IDX_W];
   assign rd_in_range = (rd_addr < ADDR_LIMIT);
   assign rd_idx      = rd_addr[2 +: IDX_W];

   always_comb begin
      w_state_n  = w_state;
      aw_held_n  = aw_held;
      w_held_n   = w_held;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      w_cnt_n    = w_cnt;
      bvalid_n   = S_AXIL_bvalid;
      bresp_n    = S_AXIL_bresp;
      wr_count_n = o_wr_count;
      reg_we     = 1'b0;
      case (w_state)
         W_COLLECT: begin
            if (S_AXIL_awvalid && S_AXIL_awready) begin
               aw_held_n = 1'b1;
               wr_addr_n = S_AXIL_awaddr;
            end
            if (S_AXIL_wvalid && S_AXIL_wready) begin
               w_held_n  = 1'b1;
               wr_data_n = S_AXIL_wdata;
            end
            if (aw_held_n && w_held_n) begin
               aw_held_n = 1'b0;
               w_held_n  = 1'b0;
               w_cnt_n   = DLY;
               w_state_n = W_DELAY;
            end
         end
         W_DELAY: begin
            // counter still at its load value only on the first W_DELAY cycle
            if (w_cnt == DLY) begin
               reg_we  = wr_in_range;
               bresp_n = wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (w_cnt == 8'd0) begin
               bvalid_n  = 1'b1;
               w_state_n = W_RESP;
            end else begin
               w_cnt_n = w_cnt - 8'd1;
            end
         end
         W_RESP: begin
            if (S_AXIL_bready) begin
               bvalid_n   = 1'b0;
               wr_count_n = o_wr_count + 16'd1;
               w_state_n  = W_COLLECT;
            end
         end
         default: w_state_n = W_COLLECT;
      endcase
      awready_n = (w_state_n == W_COLLECT) && !aw_held_n;
      wready_n  = (w_state_n == W_COLLECT) && !w_held_n;
   end

   always_ff @(posedge clk) begin
      if (ap_rst) begin
         w_state        <= W_COLLECT;
         aw_held        <= 1'b0;
         w_held         <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
         w_cnt          <= '0;
         S_AXIL_awready <= 1'b0;
         S_AXIL_wready  <= 1'b0;
         S_AXIL_bvalid  <= 1'b0;
         S_AXIL_bresp   <= RESP_OKAY;
         o_wr_count     <= '0;
      end else begin
         w_state        <= w_state_n;
         aw_held        <= aw_held_n;
         w_held         <= w_held_n;
         wr_addr        <= wr_addr_n;
         wr_data        <= wr_data_n;
         w_cnt          <= w_cnt_n;
         S_AXIL_awready <= awready_n;
         S_AXIL_wready  <= wready_n;
         S_AXIL_bvalid  <= bvalid_n;
         S_AXIL_bresp   <= bresp_n;
         o_wr_count     <= wr_count_n;
      end
   end

   always_ff @(posedge clk) begin
      if (ap_rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (reg_we) begin
         regs[wr_idx] <= wr_data;
      end
   end

   // rdata samples regs before any same-edge write lands, so collisions return the old value
   always_comb begin
      r_state_n  = r_state;
      rd_addr_n  = rd_addr;
      r_cnt_n    = r_cnt;
      rvalid_n   = S_AXIL_rvalid;
      rdata_n    = S_AXIL_rdata;
      rresp_n    = S_AXIL_rresp;
      rd_count_n = o_rd_count;
      case (r_state)
         R_IDLE: begin
            if (S_AXIL_arvalid && S_AXIL_arready) begin
               rd_addr_n = S_AXIL_araddr;
               r_cnt_n   = DLY;
               r_state_n = R_DELAY;
            end
         end
         R_DELAY: begin
            if (r_cnt == 8'd0) begin
               rvalid_n  = 1'b1;
               rdata_n   = rd_in_range ? regs[rd_idx] : '0;
               rresp_n   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
               r_state_n = R_RESP;
            end else begin
               r_cnt_n = r_cnt - 8'd1;
            end
         end
         R_RESP: begin
            if (S_AXIL_rready) begin
               rvalid_n   = 1'b0;
               rd_count_n = o_rd_count + 16'd1;
               r_state_n  = R_IDLE;
            end
         end
         default: r_state_n = R_IDLE;
      endcase
      arready_n = (r_state_n == R_IDLE);
   end

   always_ff @(posedge clk) begin
      if (ap_rst) begin
         r_state        <= R_IDLE;
         rd_addr        <= '0;
         r_cnt          <= '0;
         S_AXIL_arready <= 1'b0;
         S_AXIL_rvalid  <= 1'b0;
         S_AXIL_rdata   <= '0;
         S_AXIL_rresp   <= RESP_OKAY;
         o_rd_count     <= '0;
      end else begin
         r_state        <= r_state_n;
         rd_addr        <= rd_addr_n;
         r_cnt          <= r_cnt_n;
         S_AXIL_arready <= arready_n;
         S_AXIL_rvalid  <= rvalid_n;
         S_AXIL_rdata   <= rdata_n;
         S_AXIL_rresp   <= rresp_n;
         o_rd_count     <= rd_count_n;
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_subordinate.sv
// Bench for axi_lite_reg_subordinate: a zero-delay instance for function and
// randomized traffic, plus a RESP_DELAY=20 instance for latency and back-pressure.

module tb_axi_lite_reg_subordinate;
   localparam int NREG = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic ap_rst;

   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [1:0]  bresp, rresp;
   logic [15:0] wr_count, rd_count;

   logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
   logic        d_arvalid, d_arready, d_rvalid, d_rready;
   logic [31:0] d_awaddr, d_wdata, d_araddr, d_rdata;
   logic [1:0]  d_bresp, d_rresp;
   logic [15:0] d_wr_count, d_rd_count;

   axi_lite_reg_subordinate #(.NUM_REGS(NREG), .RESP_DELAY(0)) u_dut (
      .clk(clk), .ap_rst(ap_rst),
      .S_AXIL_awvalid(awvalid), .S_AXIL_awready(awready), .S_AXIL_awaddr(awaddr),
      .S_AXIL_wvalid(wvalid), .S_AXIL_wready(wready), .S_AXIL_wdata(wdata),
      .S_AXIL_bvalid(bvalid), .S_AXIL_bready(bready), .S_AXIL_bresp(bresp),
      .S_AXIL_arvalid(arvalid), .S_AXIL_arready(arready), .S_AXIL_araddr(araddr),
      .S_AXIL_rvalid(rvalid), .S_AXIL_rready(rready), .S_AXIL_rdata(rdata),
      .S_AXIL_rresp(rresp), .o_wr_count(wr_count), .o_rd_count(rd_count));

   axi_lite_reg_subordinate #(.NUM_REGS(NREG), .RESP_DELAY(20)) u_dut_dly (
      .clk(clk), .ap_rst(ap_rst),
      .S_AXIL_awvalid(d_awvalid), .S_AXIL_awready(d_awready), .S_AXIL_awaddr(d_awaddr),
      .S_AXIL_wvalid(d_wvalid), .S_AXIL_wready(d_wready), .S_AXIL_wdata(d_wdata),
      .S_AXIL_bvalid(d_bvalid), .S_AXIL_bready(d_bready), .S_AXIL_bresp(d_bresp),
      .S_AXIL_arvalid(d_arvalid), .S_AXIL_arready(d_arready), .S_AXIL_araddr(d_araddr),
      .S_AXIL_rvalid(d_rvalid), .S_AXIL_rready(d_rready), .S_AXIL_rdata(d_rdata),
      .S_AXIL_rresp(d_rresp), .o_wr_count(d_wr_count), .o_rd_count(d_rd_count));

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] model [NREG];
   int exp_wr = 0;
   int exp_rd = 0;

   function automatic bit in_rng(input logic [31:0] a);
      return a < 32'(4 * NREG);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) % NREG);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int bp, input string tag);
      int c = 0;
      int n = 0;
      bit aw_p = 1'b1;
      bit w_p = 1'b1;
      bit haw, hw;
      logic [1:0] exp_resp;
      awaddr = addr;
      wdata  = data;
      while ((aw_p || w_p) && c < 100) begin
         awvalid = aw_p && (c >= aw_dly);
         wvalid  = w_p && (c >= w_dly);
         haw = awvalid && awready;
         hw  = wvalid && wready;
         tick;
         c++;
         if (haw) aw_p = 1'b0;
         if (hw) w_p = 1'b0;
         if (aw_p != w_p) begin
            n_cmp++;
            if ((!aw_p && awready) || (!w_p && wready)) begin
               n_err++;
               $display("FAIL %s ready_drop: awready=%b wready=%b want captured side 0", tag, awready, wready);
            end
         end
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      n_cmp++;
      if (aw_p || w_p) begin
         n_err++;
         $display("FAIL %s write_accept: timed out aw_pending=%b w_pending=%b", tag, aw_p, w_p);
         return;
      end
      while (!bvalid && n < 100) begin
         tick;
         n++;
      end
      exp_resp = in_rng(addr) ? 2'd0 : 2'd2;
      if (in_rng(addr)) model[idx_of(addr)] = data;
      n_cmp++;
      if (n !== 1) begin
         n_err++;
         $display("FAIL %s bvalid_latency: got %0d want 1", tag, n);
      end
      n_cmp++;
      if (bresp !== exp_resp) begin
         n_err++;
         $display("FAIL %s bresp: got %0d want %0d", tag, bresp, exp_resp);
      end
      repeat (bp) begin
         tick;
         n_cmp++;
         if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0) begin
            n_err++;
            $display("FAIL %s b_hold: bvalid=%b bresp=%0d awready=%b want 1/%0d/0", tag, bvalid, bresp, awready, exp_resp);
         end
      end
      bready = 1'b1;
      tick;
      bready = 1'b0;
      exp_wr++;
      n_cmp++;
      if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || wr_count !== 16'(exp_wr)) begin
         n_err++;
         $display("FAIL %s b_done: bvalid=%b awready=%b wready=%b wr_count=%0d want 0/1/1/%0d",
                  tag, bvalid, awready, wready, wr_count, exp_wr);
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input int bp, input string tag);
      int n = 0;
      logic [31:0] exp_data;
      logic [1:0] exp_resp;
      araddr  = addr;
      arvalid = 1'b1;
      while (!arready && n < 100) begin
         tick;
         n++;
      end
      tick;
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 100) begin
         tick;
         n++;
      end
      exp_data = in_rng(addr) ? model[idx_of(addr)] : 32'd0;
      exp_resp = in_rng(addr) ? 2'd0 : 2'd2;
      n_cmp++;
      if (n !== 1) begin
         n_err++;
         $display("FAIL %s rvalid_latency: got %0d want 1", tag, n);
      end
      n_cmp++;
      if (rdata !== exp_data || rresp !== exp_resp) begin
         n_err++;
         $display("FAIL %s rdata: got %h/%0d want %h/%0d", tag, rdata, rresp, exp_data, exp_resp);
      end
      repeat (bp) begin
         tick;
         n_cmp++;
         if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp || arready !== 1'b0) begin
            n_err++;
            $display("FAIL %s r_hold: rvalid=%b rdata=%h arready=%b want 1/%h/0", tag, rvalid, rdata, arready, exp_data);
         end
      end
      rready = 1'b1;
      tick;
      rready = 1'b0;
      exp_rd++;
      n_cmp++;
      if (rvalid !== 1'b0 || arready !== 1'b1 || rd_count !== 16'(exp_rd)) begin
         n_err++;
         $display("FAIL %s r_done: rvalid=%b arready=%b rd_count=%0d want 0/1/%0d", tag, rvalid, arready, rd_count, exp_rd);
      end
   endtask

   task automatic test_reset;
      ap_rst = 1'b1;
      repeat (3) tick;
      n_cmp++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'd0 || rresp !== 2'd0 ||
          rdata !== 32'd0 || wr_count !== 16'd0 || rd_count !== 16'd0) begin
         n_err++;
         $display("FAIL reset_outputs: rdy=%b%b%b bv=%b rv=%b rdata=%h cnt=%0d/%0d want all 0",
                  awready, wready, arready, bvalid, rvalid, rdata, wr_count, rd_count);
      end
      ap_rst = 1'b0;
      tick;
      n_cmp++;
      if ({awready, wready, arready} !== 3'b111 || {d_awready, d_wready, d_arready} !== 3'b111) begin
         n_err++;
         $display("FAIL reset_release_ready: got %b%b%b / %b%b%b want 111/111",
                  awready, wready, arready, d_awready, d_wready, d_arready);
      end
   endtask

   task automatic test_write_read;
      do_write(32'h4, 32'h0F0F0F0F, 0, 0, 0, "wr_basic");
      do_read(32'h4, 0, "rd_basic");
   endtask

   task automatic test_out_of_order;
      do_write(32'h8, 32'hABCDABCD, 3, 0, 0, "wr_ooo");
      repeat (3) tick;
      n_cmp++;
      if (bvalid !== 1'b0 || wr_count !== 16'(exp_wr)) begin
         n_err++;
         $display("FAIL ooo_single_b: bvalid=%b wr_count=%0d want 0/%0d", bvalid, wr_count, exp_wr);
      end
      do_read(32'h8, 0, "rd_ooo");
   endtask

   task automatic test_out_of_range;
      do_write(32'h40, $urandom, 0, 1, 0, "wr_oor");
      do_read(32'h40, 0, "rd_oor");
      for (int i = 0; i < NREG; i++) do_read(32'(4 * i), 0, "rd_sweep");
   endtask

   task automatic test_collision;
      do_write(32'h4, 32'd5, 0, 0, 0, "wr_coll_pre");
      awaddr = 32'h4; wdata = 32'd9; araddr = 32'h4;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      tick;
      n_cmp++;
      if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'd5 || bresp !== 2'd0) begin
         n_err++;
         $display("FAIL collision_old_value: bvalid=%b rvalid=%b rdata=%0d want 1/1/5", bvalid, rvalid, rdata);
      end
      bready = 1'b1; rready = 1'b1;
      tick;
      bready = 1'b0; rready = 1'b0;
      exp_wr++; exp_rd++;
      model[1] = 32'd9;
      n_cmp++;
      if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
         n_err++;
         $display("FAIL collision_counts: got %0d/%0d want %0d/%0d", wr_count, rd_count, exp_wr, exp_rd);
      end
      do_read(32'h4, 0, "rd_coll_post");
   endtask

   task automatic test_random;
      logic [31:0] a;
      for (int i = 0; i < 30; i++) begin
         a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), "wr_rand");
         else
            do_read(a, $urandom_range(0, 3), "rd_rand");
      end
   endtask

   task automatic test_delay;
      int n = 0;
      bit ar_bad = 1'b0;
      logic [31:0] dat;
      dat = $urandom;
      d_awaddr = 32'hC; d_wdata = dat; d_awvalid = 1'b1; d_wvalid = 1'b1;
      tick;
      d_awvalid = 1'b0; d_wvalid = 1'b0;
      while (!d_bvalid && n < 100) begin
         tick;
         n++;
      end
      n_cmp++;
      if (n !== 21 || d_bresp !== 2'd0) begin
         n_err++;
         $display("FAIL dly_bvalid_latency: got %0d/%0d want 21/0", n, d_bresp);
      end
      d_bready = 1'b1;
      tick;
      d_bready = 1'b0;
      d_araddr = 32'hC; d_arvalid = 1'b1;
      tick;
      d_arvalid = 1'b0;
      n = 0;
      while (!d_rvalid && n < 100) begin
         if (d_arready !== 1'b0) ar_bad = 1'b1;
         tick;
         n++;
      end
      n_cmp++;
      if (n !== 21 || d_rdata !== dat || d_rresp !== 2'd0) begin
         n_err++;
         $display("FAIL dly_rvalid_latency: got %0d rdata=%h want 21 %h", n, d_rdata, dat);
      end
      repeat (10) begin
         tick;
         if (d_rvalid !== 1'b1 || d_rdata !== dat || d_arready !== 1'b0) ar_bad = 1'b1;
      end
      n_cmp++;
      if (ar_bad) begin
         n_err++;
         $display("FAIL dly_hold: rvalid=%b rdata=%h arready=%b want 1/%h/0 throughout", d_rvalid, d_rdata, d_arready, dat);
      end
      d_rready = 1'b1;
      tick;
      d_rready = 1'b0;
      n_cmp++;
      if (d_rvalid !== 1'b0 || d_arready !== 1'b1 || d_rd_count !== 16'd1 || d_wr_count !== 16'd1) begin
         n_err++;
         $display("FAIL dly_done: rvalid=%b arready=%b counts=%0d/%0d want 0/1/1/1", d_rvalid, d_arready, d_wr_count, d_rd_count);
      end
   endtask

   task automatic test_reset_mid_write;
      awaddr = 32'h8; awvalid = 1'b1;
      tick;
      awvalid = 1'b0;
      ap_rst = 1'b1;
      tick;
      tick;
      n_cmp++;
      if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_in_reset: bvalid=%b awready=%b wready=%b want 0/0/0", bvalid, awready, wready);
      end
      ap_rst = 1'b0;
      tick;
      n_cmp++;
      if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0 || wr_count !== 16'd0) begin
         n_err++;
         $display("FAIL midrst_release: awready=%b wready=%b bvalid=%b wr_count=%0d want 1/1/0/0",
                  awready, wready, bvalid, wr_count);
      end
      for (int i = 0; i < NREG; i++) model[i] = 32'd0;
      exp_wr = 0;
      exp_rd = 0;
      repeat (3) tick;
      n_cmp++;
      if (bvalid !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_no_b: bvalid=%b want 0", bvalid);
      end
      for (int i = 0; i < NREG; i++) do_read(32'(4 * i), 0, "rd_after_rst");
   endtask

   initial begin
      ap_rst = 1'b1;
      {awvalid, wvalid, bready, arvalid, rready} = '0;
      awaddr = '0; wdata = '0; araddr = '0;
      {d_awvalid, d_wvalid, d_bready, d_arvalid, d_rready} = '0;
      d_awaddr = '0; d_wdata = '0; d_araddr = '0;
      for (int i = 0; i < NREG; i++) model[i] = 32'd0;
      test_reset;
      test_write_read;
      test_out_of_order;
      test_out_of_range;
      test_collision;
      test_random;
      test_delay;
      test_reset_mid_write;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
